// File: rtl/sal_cfg_pkg.sv
// Shared definitions for the DDR timing register file: address map, field order,
// reset timing values and commit FSM states.
package sal_cfg_pkg;

    localparam int NUM_TIMINGS     = 11;
    localparam int OFS_CTRL        = 'h00;
    localparam int OFS_STATUS      = 'h04;
    localparam int OFS_TIMING      = 'h10;
    localparam int OFS_TIMING_LAST = OFS_TIMING + 4 * (NUM_TIMINGS - 1);

    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_LOCK_BIT    = 1;
    localparam int CTRL_CLR_ERR_BIT = 2;

    typedef enum logic [3:0] {
        F_RCD, F_RP, F_RAS, F_RFC, F_RTP, F_WTP,
        F_RRD, F_CCD, F_WTR, F_RTW, F_RDEN
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_APPLY
    } commit_state_e;

    // Reset value of each timing field, in clock cycles.
    function automatic int unsigned default_timing(input int unsigned idx);
        int unsigned val;
        case (field_e'(idx))
            F_RCD:   val = 5;
            F_RP:    val = 5;
            F_RAS:   val = 15;
            F_RFC:   val = 51;
            F_RTP:   val = 3;
            F_WTP:   val = 11;
            F_RRD:   val = 3;
            F_CCD:   val = 2;
            F_WTR:   val = 3;
            F_RTW:   val = 5;
            F_RDEN:  val = 6;
            default: val = 1;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/sal_cfg_if.sv
// Zero-wait-state APB bus between the host and the timing register file.
interface sal_cfg_if #(
    parameter int ADDR_W = 8
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/sal_cfg_commit_fsm.sv
// Commit handshake with the scheduler: waits for idle (bounded by TIMEOUT),
// then pulses commit_done for the single cycle in which active timings are loaded.
module sal_cfg_commit_fsm
    import sal_cfg_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear_err,
    input  logic       sched_idle,
    output logic       commit_req,
    output logic       commit_done,
    output logic       pending,
    output logic       timeout_err,
    output logic [7:0] commit_cnt
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);

    commit_state_e state;
    logic [CW-1:0] timer;

    // A start request is only honoured from IDLE; a timeout raised in the same
    // cycle as a software clear takes precedence so the event is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            commit_req  <= 1'b0;
            commit_done <= 1'b0;
            pending     <= 1'b0;
            timeout_err <= 1'b0;
            commit_cnt  <= 8'd0;
        end else begin
            if (clear_err)
                timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_REQ;
                        commit_req <= 1'b1;
                        pending    <= 1'b1;
                        timer      <= '0;
                    end
                end
                ST_REQ: begin
                    if (sched_idle) begin
                        state       <= ST_APPLY;
                        commit_req  <= 1'b0;
                        commit_done <= 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        state       <= ST_IDLE;
                        commit_req  <= 1'b0;
                        pending     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                ST_APPLY: begin
                    state       <= ST_IDLE;
                    commit_done <= 1'b0;
                    pending     <= 1'b0;
                    commit_cnt  <= commit_cnt + 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sal_cfg_regs.sv
// APB-programmable DDR timing register file: shadow registers written by software,
// copied to the active outputs only through the commit handshake.
module sal_cfg_regs
    import sal_cfg_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    sal_cfg_if.slave      bus,
    output logic          commit_req,
    input  logic          sched_idle,
    output logic          commit_done,
    output logic [TW-1:0] t_rcd,
    output logic [TW-1:0] t_rp,
    output logic [TW-1:0] t_ras,
    output logic [TW-1:0] t_rfc,
    output logic [TW-1:0] t_rtp,
    output logic [TW-1:0] t_wtp,
    output logic [TW-1:0] t_rrd,
    output logic [TW-1:0] t_ccd,
    output logic [TW-1:0] t_wtr,
    output logic [TW-1:0] t_rtw,
    output logic [TW-1:0] rden_lat
);
    logic [TW-1:0]     shadow [NUM_TIMINGS];
    logic [TW-1:0]     active [NUM_TIMINGS];
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] tim_ofs;
    logic [3:0]        field_idx;
    logic              transfer, is_ctrl, is_status, is_timing, mapped;
    logic              value_bad, access_err, wr_ok;
    logic              lock, pending, timeout_err;
    logic [7:0]        commit_cnt;

    assign addr      = bus.paddr;
    assign transfer  = bus.psel & bus.penable;
    assign is_ctrl   = (addr == ADDR_W'(OFS_CTRL));
    assign is_status = (addr == ADDR_W'(OFS_STATUS));
    assign is_timing = (addr >= ADDR_W'(OFS_TIMING)) && (addr <= ADDR_W'(OFS_TIMING_LAST))
                       && (addr[1:0] == 2'b00);
    assign mapped    = is_ctrl | is_status | is_timing;
    assign tim_ofs   = addr - ADDR_W'(OFS_TIMING);
    assign field_idx = 4'(tim_ofs >> 2);
    assign value_bad = (bus.pwdata[TW-1:0] == '0) || ((bus.pwdata >> TW) != '0);

    always_comb begin
        access_err = 1'b0;
        if (!mapped)
            access_err = 1'b1;
        else if (bus.pwrite) begin
            if (is_status)
                access_err = 1'b1;
            else if (is_timing && (value_bad || pending || lock))
                access_err = 1'b1;
        end
    end

    assign wr_ok       = transfer & bus.pwrite & ~access_err;
    assign bus.pslverr = transfer & access_err;
    assign bus.pready  = 1'b1;

    always_comb begin
        bus.prdata = '0;
        if (transfer && !bus.pwrite) begin
            if (is_status)
                bus.prdata = {16'h0000, commit_cnt, 5'b00000, timeout_err, lock, pending};
            else if (is_timing)
                bus.prdata = 32'(shadow[field_idx]);
        end
    end

    // Lock is sticky until reset; it freezes the shadow set but never blocks a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lock <= 1'b0;
        else if (wr_ok && is_ctrl && bus.pwdata[CTRL_LOCK_BIT])
            lock <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TIMINGS; i++) begin
                shadow[i] <= TW'(default_timing(i));
                active[i] <= TW'(default_timing(i));
            end
        end else begin
            if (wr_ok && is_timing)
                shadow[field_idx] <= bus.pwdata[TW-1:0];
            if (commit_done) begin
                for (int i = 0; i < NUM_TIMINGS; i++)
                    active[i] <= shadow[i];
            end
        end
    end

    sal_cfg_commit_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_commit (
        .clk        (clk),
        .rst        (rst),
        .start      (wr_ok & is_ctrl & bus.pwdata[CTRL_COMMIT_BIT]),
        .clear_err  (wr_ok & is_ctrl & bus.pwdata[CTRL_CLR_ERR_BIT]),
        .sched_idle (sched_idle),
        .commit_req (commit_req),
        .commit_done(commit_done),
        .pending    (pending),
        .timeout_err(timeout_err),
        .commit_cnt (commit_cnt)
    );

    assign t_rcd    = active[int'(F_RCD)];
    assign t_rp     = active[int'(F_RP)];
    assign t_ras    = active[int'(F_RAS)];
    assign t_rfc    = active[int'(F_RFC)];
    assign t_rtp    = active[int'(F_RTP)];
    assign t_wtp    = active[int'(F_WTP)];
    assign t_rrd    = active[int'(F_RRD)];
    assign t_ccd    = active[int'(F_CCD)];
    assign t_wtr    = active[int'(F_WTR)];
    assign t_rtw    = active[int'(F_RTW)];
    assign rden_lat = active[int'(F_RDEN)];

endmodule
